// File: rtl/tlc_vehicle_requester.sv
// Vehicle-side requester: debounces the road sensor, holds car until green, counts serves.
// Define TLC_VEHICLE_SEQ_CHECK_EN to build the red/yellow/green sequence checker behind seq_error.
module tlc_vehicle_requester #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 16,
   parameter int COUNT_W         = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               sensor_raw,
   input  logic               red,
   input  logic               yellow,
   input  logic               green,
   output logic               car,
   output logic [COUNT_W-1:0] served_count,
   output logic               wait_timeout,
   output logic               seq_error
);

   localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, REQUEST, SERVED} state_t;

   state_t        state_reg;
   logic [DW-1:0] deb_cnt_reg;
   logic [WW-1:0] wait_cnt_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         deb_cnt_reg  <= '0;
         wait_cnt_reg <= '0;
         car          <= 1'b0;
         served_count <= '0;
         wait_timeout <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (sensor_raw) begin
                  state_reg   <= DEBOUNCE;
                  deb_cnt_reg <= DW'(1);
               end
            end
            DEBOUNCE: begin
               if (!sensor_raw) begin
                  state_reg   <= IDLE;
                  deb_cnt_reg <= '0;
               end else if (deb_cnt_reg == DEB_LAST) begin
                  state_reg    <= REQUEST;
                  deb_cnt_reg  <= '0;
                  wait_cnt_reg <= '0;
                  car          <= 1'b1;
               end else begin
                  deb_cnt_reg <= deb_cnt_reg + DW'(1);
               end
            end
            REQUEST: begin
               // Green beats a simultaneous timeout; the sensor is ignored while waiting.
               if (green) begin
                  state_reg <= SERVED;
                  car       <= 1'b0;
                  if (served_count != {COUNT_W{1'b1}})
                     served_count <= served_count + COUNT_W'(1);
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  wait_timeout <= 1'b1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + WW'(1);
               end
            end
            SERVED: begin
               if (!sensor_raw)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef TLC_VEHICLE_SEQ_CHECK_EN
   logic [2:0] lights;
   logic [2:0] prev_reg;
   logic       hist_valid_reg;
   logic       seq_error_reg;
   logic       legal_step;

   assign lights = {red, yellow, green};

   // Only hold, R->Y, Y->G and G->R are allowed between consecutive samples.
   always_comb begin
      legal_step = (lights == prev_reg)
                || (prev_reg == 3'b100 && lights == 3'b010)
                || (prev_reg == 3'b010 && lights == 3'b001)
                || (prev_reg == 3'b001 && lights == 3'b100);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_reg       <= 3'b000;
         hist_valid_reg <= 1'b0;
         seq_error_reg  <= 1'b0;
      end else if (!$onehot(lights)) begin
         seq_error_reg  <= 1'b1;
         hist_valid_reg <= 1'b0;
      end else begin
         if (hist_valid_reg && !legal_step)
            seq_error_reg <= 1'b1;
         hist_valid_reg <= 1'b1;
         prev_reg       <= lights;
      end
   end

   assign seq_error = seq_error_reg;
`else
   logic unused_lights;
   assign unused_lights = red ^ yellow;
   assign seq_error     = 1'b0;
`endif

endmodule

// File: tb/tb_tlc_vehicle_requester.sv
// Randomized and directed bench for tlc_vehicle_requester against a behavioural model.
module tb_tlc_vehicle_requester;

   localparam int DEB = 4;
   localparam int TO  = 16;
   localparam int CW  = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          sensor_raw = 1'b0;
   logic          red = 1'b1, yellow = 1'b0, green = 1'b0;
   logic          car;
   logic [CW-1:0] served_count;
   logic          wait_timeout;
   logic          seq_error;

   tlc_vehicle_requester #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO), .COUNT_W(CW)) dut (
      .clock(clock), .reset(reset), .sensor_raw(sensor_raw),
      .red(red), .yellow(yellow), .green(green),
      .car(car), .served_count(served_count),
      .wait_timeout(wait_timeout), .seq_error(seq_error)
   );

   always #5 clock = ~clock;

`ifdef TLC_VEHICLE_SEQ_CHECK_EN
   localparam bit CHECKER_ON = 1'b1;
`else
   localparam bit CHECKER_ON = 1'b0;
`endif

   // Behavioural model: run of consecutive highs, a pending request, a parked vehicle.
   int  m_run, m_waited, m_count, m_prev;
   bit  m_pending, m_parked, m_timeout, m_err;
   int  n_checks = 0, n_pass = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_step();
      int idx;
      if (reset) begin
         m_run = 0; m_waited = 0; m_count = 0; m_prev = -1;
         m_pending = 0; m_parked = 0; m_timeout = 0; m_err = 0;
         return;
      end
      if (m_pending) begin
         if (green) begin
            m_pending = 0; m_parked = 1;
            m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
         end else if (m_waited == TO - 1) m_timeout = 1;
         else m_waited++;
      end else if (m_parked) begin
         if (!sensor_raw) m_parked = 0;
      end else if (sensor_raw) begin
         m_run++;
         if (m_run == DEB) begin m_pending = 1; m_waited = 0; m_run = 0; end
      end else m_run = 0;
      // Lights as a ring R=0,Y=1,G=2: legal moves are stay or advance by one.
      if (int'(red) + int'(yellow) + int'(green) != 1) begin
         m_err = m_err | CHECKER_ON; m_prev = -1;
      end else begin
         idx = red ? 0 : (yellow ? 1 : 2);
         if (m_prev >= 0 && idx != m_prev && idx != (m_prev + 1) % 3) m_err = m_err | CHECKER_ON;
         m_prev = idx;
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clock);
      model_step();
      #1;
      check({tag, ".car"}, car, m_pending);
      check({tag, ".count"}, served_count, m_count);
      check({tag, ".timeout"}, wait_timeout, m_timeout);
      check({tag, ".seq"}, seq_error, m_err);
   endtask

   task automatic lights(input int idx);
      red = (idx == 0); yellow = (idx == 1); green = (idx == 2);
   endtask

   task automatic do_reset();
      reset = 1'b1; tick("rst"); reset = 1'b0;
   endtask

   task automatic enter_request(input int light);
      lights(light); sensor_raw = 1'b1;
      repeat (DEB) tick("deb");
   endtask

   initial begin
      lights(0);
      reset = 1'b1;
      tick("rst"); tick("rst");
      check("reset_car", car, 0);
      check("reset_count", served_count, 0);
      reset = 1'b0;

      // Debounce pass, then serve via R,Y,G.
      enter_request(0);
      check("deb_car", car, 1);
      check("deb_count", served_count, 0);
      tick("srvR"); lights(1); tick("srvY"); lights(2); tick("srvG");
      check("serve_car", car, 0);
      check("serve_count", served_count, 1);
      repeat (10) tick("hold");
      check("no_double", served_count, 1);
      sensor_raw = 1'b0; tick("leave"); lights(0); tick("leave");

      // Bounce reject then fresh debounce.
      do_reset(); lights(0);
      sensor_raw = 1'b1; repeat (3) tick("b1");
      sensor_raw = 1'b0; tick("b0");
      sensor_raw = 1'b1; repeat (3) tick("b2");
      check("bounce_car", car, 0);
      tick("b3");
      check("bounce_car4", car, 1);

      // Timeout with red held.
      do_reset(); enter_request(0);
      repeat (TO - 1) tick("to");
      check("to_pre", wait_timeout, 0);
      tick("to");
      check("to_set", wait_timeout, 1);
      check("to_car", car, 1);
      repeat (5) tick("to_sat");

      // Green on the timeout edge wins.
      do_reset(); enter_request(0);
      lights(1); repeat (TO - 1) tick("tg");
      lights(2); tick("tg");
      check("tg_timeout", wait_timeout, 0);
      check("tg_count", served_count, 1);

      // Illegal transition R->G, sticky.
      do_reset(); lights(0); sensor_raw = 1'b0; tick("sq");
      lights(2); tick("sq");
      check("seq_rg", seq_error, CHECKER_ON);
      lights(0); repeat (3) tick("sq");
      check("seq_sticky", seq_error, CHECKER_ON);

      // Two lights at once.
      do_reset(); red = 1'b1; yellow = 1'b0; green = 1'b1; tick("sq2");
      check("seq_two", seq_error, CHECKER_ON);

      // Saturation, then reset out of REQUEST.
      do_reset(); lights(0); tick("sat");
      for (int v = 0; v < 5; v++) begin
         enter_request(0);
         lights(1); tick("sat"); lights(2); tick("sat");
         sensor_raw = 1'b0; tick("sat"); lights(0); tick("sat");
      end
      check("sat_count", served_count, CMAX);
      enter_request(0);
      check("pre_rst_car", car, 1);
      do_reset();
      check("rst_car", car, 0);
      check("rst_count", served_count, 0);
      check("rst_timeout", wait_timeout, 0);
      check("rst_seq", seq_error, 0);

      // Randomized run against the model.
      begin
         int cur = 0;
         for (int i = 0; i < 4000; i++) begin
            int r = $urandom_range(0, 99);
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) < 15) sensor_raw = ~sensor_raw;
            if (r < 70) lights(cur);
            else if (r < 92) begin cur = (cur + 1) % 3; lights(cur); end
            else if (r < 97) begin cur = $urandom_range(0, 2); lights(cur); end
            else {red, yellow, green} = 3'($urandom_range(0, 7));
            tick("rnd");
         end
         reset = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
